// File: rtl/qsp_issue_sched.sv
// Round-robin issue scheduler feeding qsp_core from NUM_IQ instruction queues.
// Inserts bubbles on distance-2/3 RAW hazards (distance 1 is covered by WB->EX forwarding).
module qsp_issue_sched #(
    parameter int unsigned  NUM_IQ   = 4,
    parameter logic [31:0]  NOP_INSN = 32'h0000_0000,
    localparam int unsigned SRC_W    = $clog2(NUM_IQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [NUM_IQ-1:0]     iq_valid,
    input  logic [NUM_IQ*32-1:0]  iq_instr,
    output logic [NUM_IQ-1:0]     iq_ready,
    output logic [31:0]           instr_out,
    output logic                  issue_valid,
    output logic [SRC_W-1:0]      issue_src,
    output logic                  illegal_drop,
    output logic [15:0]           stall_cnt
);

    localparam logic [4:0] S0_IDX     = 5'd0;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;

    logic [SRC_W-1:0] rr_q, rr_d;
    logic [31:0]      instr_q, instr_d;
    logic             valid_q, valid_d;
    logic [SRC_W-1:0] src_q, src_d;
    logic             drop_q, drop_d;
    logic [15:0]      stall_q, stall_d;
    // History index 0 is h1 (the slot currently on instr_out), 2 is h3.
    logic [2:0]       h_we_q;
    logic [2:0][4:0]  h_rd_q;
    logic             slot_we;

    logic             cand_found;
    logic [SRC_W-1:0] cand_idx;
    logic [SRC_W-1:0] scan_pos;
    int unsigned      scan_idx;
    logic [31:0]      cand_instr;

    logic [4:0]       dec_rd, dec_rs1, dec_rs2;
    logic             dec_we, dec_use_imm, dec_illegal;
    logic             hazard, accept, stall;

    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        scan_idx   = 0;
        scan_pos   = '0;
        for (int unsigned k = 0; k < NUM_IQ; k++) begin
            scan_idx = 32'(rr_q) + k;
            if (scan_idx >= NUM_IQ) scan_idx = scan_idx - NUM_IQ;
            scan_pos = SRC_W'(scan_idx);
            if (!cand_found && iq_valid[scan_pos]) begin
                cand_found = 1'b1;
                cand_idx   = scan_pos;
            end
        end
    end

    assign cand_instr = iq_instr[{cand_idx, 5'b0} +: 32];

    // Candidate decode: rd[11:7], rs1[19:15], rs2[24:20], opcode[6:0].
    assign dec_rd  = cand_instr[11:7];
    assign dec_rs1 = cand_instr[19:15];
    assign dec_rs2 = cand_instr[24:20];

    always_comb begin
        dec_we      = 1'b0;
        dec_use_imm = 1'b0;
        dec_illegal = 1'b0;
        case (cand_instr[6:0])
            OPC_OP:               dec_we = 1'b1;
            OPC_OPIMM, OPC_LOAD: begin
                dec_we      = 1'b1;
                dec_use_imm = 1'b1;
            end
            OPC_STORE, OPC_BRANCH: dec_we = 1'b0;
            default:              dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        hazard = 1'b0;
        for (int d = 1; d < 3; d++) begin
            if (h_we_q[d] && (h_rd_q[d] != S0_IDX) &&
                ((h_rd_q[d] == dec_rs1) || (!dec_use_imm && (h_rd_q[d] == dec_rs2)))) begin
                hazard = 1'b1;
            end
        end
    end

    assign accept = rst_n && en && cand_found && !hazard;
    assign stall  = en && cand_found && hazard;

    always_comb begin
        iq_ready = '0;
        if (accept) iq_ready[cand_idx] = 1'b1;
    end

    always_comb begin
        instr_d = NOP_INSN;
        valid_d = 1'b0;
        src_d   = src_q;
        drop_d  = 1'b0;
        stall_d = stall_q;
        rr_d    = rr_q;
        slot_we = 1'b0;
        if (accept) begin
            rr_d = (cand_idx == SRC_W'(NUM_IQ - 1)) ? '0 : cand_idx + 1'b1;
            if (dec_illegal) begin
                drop_d = 1'b1;
            end else begin
                instr_d = cand_instr;
                valid_d = 1'b1;
                src_d   = cand_idx;
                slot_we = dec_we;
            end
        end else if (stall && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q    <= '0;
            instr_q <= NOP_INSN;
            valid_q <= 1'b0;
            src_q   <= '0;
            drop_q  <= 1'b0;
            stall_q <= '0;
            h_we_q  <= '0;
            h_rd_q  <= '0;
        end else begin
            rr_q    <= rr_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            src_q   <= src_d;
            drop_q  <= drop_d;
            stall_q <= stall_d;
            h_we_q  <= {h_we_q[1:0], slot_we};
            h_rd_q  <= {h_rd_q[1:0], dec_rd};
        end
    end

    assign instr_out    = instr_q;
    assign issue_valid  = valid_q;
    assign issue_src    = src_q;
    assign illegal_drop = drop_q;
    assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_qsp_issue_sched.sv
// Bench for qsp_issue_sched: queue-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_qsp_issue_sched;

    localparam int          N   = 4;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic [N-1:0]   iq_valid;
    logic [N*32-1:0] iq_instr;
    logic [N-1:0]   iq_ready;
    logic [31:0]    instr_out;
    logic           issue_valid;
    logic [1:0]     issue_src;
    logic           illegal_drop;
    logic [15:0]    stall_cnt;

    qsp_issue_sched #(.NUM_IQ(N), .NOP_INSN(NOP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .iq_valid     (iq_valid),
        .iq_instr     (iq_instr),
        .iq_ready     (iq_ready),
        .instr_out    (instr_out),
        .issue_valid  (issue_valid),
        .issue_src    (issue_src),
        .illegal_drop (illegal_drop),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; logic [4:0] rd; } slot_t;
    typedef struct { logic v; logic [1:0] src; logic [31:0] ins; logic drop; } obs_t;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] qs[N][$];
    logic [N-1:0] hide;
    slot_t       hist[$];
    obs_t        obs[$];
    logic [N-1:0] last_ready;

    int unsigned m_rr;
    logic [31:0] m_instr;
    logic        m_valid;
    logic [1:0]  m_src;
    logic        m_drop;
    logic [15:0] m_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rt(input int rd, input int rs1, input int rs2);
        return {7'h00, 5'(rs2), 5'(rs1), 3'h0, 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] it(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'h0, 5'(rd), 7'h13};
    endfunction

    // Reference decode: which opcodes write, which take an immediate, which are illegal.
    function automatic void dec(input logic [31:0] i, output logic we, output logic ui,
                                output logic ill);
        we = 1'b0; ui = 1'b0; ill = 1'b0;
        if (i[6:0] == 7'h33) we = 1'b1;
        else if (i[6:0] == 7'h13 || i[6:0] == 7'h03) begin we = 1'b1; ui = 1'b1; end
        else if (i[6:0] != 7'h23 && i[6:0] != 7'h63) ill = 1'b1;
    endfunction

    function automatic void model_reset();
        slot_t z;
        z.we = 1'b0; z.rd = '0;
        m_rr = 0; m_instr = NOP; m_valid = 1'b0; m_src = '0; m_drop = 1'b0; m_stall = '0;
        hist.delete();
        repeat (3) hist.push_back(z);
    endfunction

    function automatic void clear_queues();
        for (int i = 0; i < N; i++) qs[i].delete();
        hide = '0;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            iq_valid[i] = (qs[i].size() > 0) && !hide[i];
            iq_instr[32*i +: 32] = (qs[i].size() > 0) ? qs[i][0] : 32'hDEAD_BEEF;
        end
    endtask

    // One cycle: starts and ends at a falling edge.
    task automatic step();
        logic [N-1:0] exp_ready;
        int           cand;
        int           idx;
        logic         we, ui, ill, haz;
        logic [31:0]  ins;
        slot_t        s;
        obs_t         o;
        drive();
        #1;
        cand = -1;
        for (int k = 0; k < N; k++) begin
            idx = (int'(m_rr) + k) % N;
            if (cand < 0 && qs[idx].size() > 0 && !hide[idx]) cand = idx;
        end
        exp_ready = '0; haz = 1'b0; we = 1'b0; ui = 1'b0; ill = 1'b0; ins = NOP;
        if (en && cand >= 0) begin
            ins = qs[cand][0];
            dec(ins, we, ui, ill);
            for (int d = 1; d < 3; d++)
                if (hist[d].we && hist[d].rd != 5'd0 &&
                    (hist[d].rd == ins[19:15] || (!ui && hist[d].rd == ins[24:20]))) haz = 1'b1;
            if (!haz) exp_ready[cand] = 1'b1;
        end
        chk("iq_ready", 32'(iq_ready), 32'(exp_ready));
        last_ready = iq_ready;
        @(posedge clk);
        s.we = 1'b0; s.rd = '0;
        m_instr = NOP; m_valid = 1'b0; m_drop = 1'b0;
        if (en && cand >= 0) begin
            if (haz) begin
                if (m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            end else begin
                void'(qs[cand].pop_front());
                m_rr = (cand + 1) % N;
                if (ill) m_drop = 1'b1;
                else begin
                    m_valid = 1'b1; m_instr = ins; m_src = 2'(cand);
                    s.we = we; s.rd = ins[11:7];
                end
            end
        end
        hist.push_front(s);
        void'(hist.pop_back());
        #1;
        chk("instr_out", instr_out, m_instr);
        chk("issue_valid", 32'(issue_valid), 32'(m_valid));
        chk("illegal_drop", 32'(illegal_drop), 32'(m_drop));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        if (m_valid) chk("issue_src", 32'(issue_src), 32'(m_src));
        o.v = issue_valid; o.src = issue_src; o.ins = instr_out; o.drop = illegal_drop;
        obs.push_back(o);
        @(negedge clk);
    endtask

    task automatic check_reset_values();
        chk("rst_instr_out", instr_out, NOP);
        chk("rst_issue_valid", 32'(issue_valid), 32'd0);
        chk("rst_issue_src", 32'(issue_src), 32'd0);
        chk("rst_illegal_drop", 32'(illegal_drop), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_iq_ready", 32'(iq_ready), 32'd0);
    endtask

    // Called at a falling edge; returns at a falling edge with reset released.
    task automatic do_reset();
        drive();
        rst_n = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        obs.delete();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int          sel;
        r   = $urandom;
        sel = $urandom_range(0, 11);
        case (sel)
            0, 1, 2: r[6:0] = 7'h33;
            3, 4:    r[6:0] = 7'h13;
            5:       r[6:0] = 7'h03;
            6:       r[6:0] = 7'h23;
            7:       r[6:0] = 7'h63;
            8:       r[6:0] = 7'h7F;
            default: r[6:0] = 7'h33;
        endcase
        r[11:7]  = 5'($urandom_range(0, 4));
        r[19:15] = 5'($urandom_range(0, 4));
        r[24:20] = 5'($urandom_range(0, 4));
        return r;
    endfunction

    initial begin
        int          rr_exp[5];
        logic [31:0] b;
        rr_exp = '{0, 1, 2, 3, 0};
        rst_n = 1'b0; en = 1'b0; iq_valid = '0; iq_instr = '0; hide = '0;
        model_reset();
        @(negedge clk);
        clear_queues();
        do_reset();
        en = 1'b1;

        // Round robin across four independent queues.
        qs[0].push_back(rt(1, 10, 11)); qs[0].push_back(rt(5, 12, 13));
        qs[1].push_back(rt(2, 14, 15)); qs[2].push_back(rt(3, 16, 17));
        qs[3].push_back(rt(4, 18, 19));
        repeat (5) step();
        for (int i = 0; i < 5; i++) begin
            chk("rr_src", 32'(obs[i].src), 32'(rr_exp[i]));
            chk("rr_valid", 32'(obs[i].v), 32'd1);
        end

        // Distance 1 dependency issues back to back.
        clear_queues(); do_reset(); en = 1'b1;
        b = rt(4, 3, 5);
        qs[0].push_back(rt(3, 1, 2)); qs[0].push_back(b);
        repeat (2) step();
        chk("d1_valid", 32'(obs[1].v), 32'd1);
        chk("d1_instr", obs[1].ins, b);
        chk("d1_stall", 32'(stall_cnt), 32'd0);

        // Distance 2 dependency costs two bubbles.
        clear_queues(); do_reset(); en = 1'b1;
        qs[0].push_back(rt(3, 1, 2)); qs[0].push_back(rt(6, 7, 8)); qs[0].push_back(b);
        repeat (5) step();
        chk("d2_bubble1", 32'(obs[2].v), 32'd0);
        chk("d2_bubble2", 32'(obs[3].v), 32'd0);
        chk("d2_issue", obs[4].ins, b);
        chk("d2_stall", 32'(stall_cnt), 32'd2);

        // Immediate operand and S0 writer never stall.
        clear_queues(); do_reset(); en = 1'b1;
        qs[0].push_back(it(7, 1, 0)); qs[0].push_back(rt(6, 1, 2)); qs[0].push_back(it(8, 9, 7));
        qs[0].push_back(rt(0, 1, 2)); qs[0].push_back(rt(6, 1, 2)); qs[0].push_back(rt(8, 0, 0));
        repeat (6) step();
        chk("imm_valid", 32'(obs[2].v), 32'd1);
        chk("s0_valid", 32'(obs[5].v), 32'd1);
        chk("imm_s0_stall", 32'(stall_cnt), 32'd0);

        // Illegal instruction from IQ2 is consumed and dropped.
        clear_queues(); do_reset(); en = 1'b1;
        qs[2].push_back(32'h0000_007F);
        step();
        chk("ill_ready", 32'(last_ready), 32'h4);
        chk("ill_drop", 32'(obs[0].drop), 32'd1);
        chk("ill_instr", obs[0].ins, NOP);
        chk("ill_valid", 32'(obs[0].v), 32'd0);
        step();
        chk("ill_drop_pulse", 32'(obs[1].drop), 32'd0);

        // Reset while B is stalled: B stays queued and issues after release.
        clear_queues(); do_reset(); en = 1'b1;
        qs[0].push_back(rt(3, 1, 2)); qs[0].push_back(rt(6, 7, 8)); qs[0].push_back(b);
        repeat (3) step();
        chk("pre_rst_stall", 32'(stall_cnt), 32'd1);
        do_reset();
        en = 1'b1;
        step();
        chk("post_rst_valid", 32'(obs[0].v), 32'd1);
        chk("post_rst_instr", obs[0].ins, b);

        // Randomized traffic with hazards, illegal ops, enable gaps and valid dropouts.
        clear_queues(); do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (qs[i].size() < 3 && $urandom_range(0, 1) == 1) qs[i].push_back(rand_instr());
                hide[i] = ($urandom_range(0, 7) == 0);
            end
            en = ($urandom_range(0, 9) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/qsp_issue_sched.md
QSP_ISSUE_SCHED -- requirements
Module: qsp_issue_sched

Interface
REQ-001 SHALL have parameter NUM_IQ, default 4, meaning the number of instruction-queue requesters (range 2..8).
REQ-002 SHALL have parameter NOP_INSN, default 32'h0000_0000, meaning the encoding emitted as a bubble (qsp_decode: we=0).
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port en, input, 1 bit: issue enable.
REQ-006 SHALL have port iq_valid, input, NUM_IQ bits: per-queue instruction available.
REQ-007 SHALL have port iq_instr, input, NUM_IQ*32 bits: packed instructions, queue i at [32*i+31:32*i].
REQ-008 SHALL have port iq_ready, output, NUM_IQ bits: per-queue accept, combinational, at most one bit high.
REQ-009 SHALL have port instr_out, output, 32 bits: registered instruction to the qsp_core instruction input.
REQ-010 SHALL have port issue_valid, output, 1 bit: registered, high when instr_out is a real instruction rather than a bubble.
REQ-011 SHALL have port issue_src, output, clog2(NUM_IQ) bits: registered source queue of instr_out.
REQ-012 SHALL have port illegal_drop, output, 1 bit: one-cycle registered pulse when an illegal instruction was consumed.
REQ-013 SHALL have port stall_cnt, output, 16 bits: saturating count of hazard bubbles.

Function
REQ-014 SHALL select the candidate queue round-robin: first valid queue at or after rr_ptr, wrapping from NUM_IQ-1 to 0.
REQ-015 SHALL decode the candidate with a qsp_decode instance to obtain rs1, rs2, rd, we, use_imm and illegal.
REQ-016 SHALL keep a 3-entry history of issued slots, h1..h3 (distance 1..3), each holding {we, rd}, with bubbles recorded as we=0; h1 corresponds to the current instr_out.
REQ-017 SHALL flag a hazard when the candidate's rs1, or its rs2 when use_imm=0, equals the rd of h2 or h3 with we=1 and rd!=S0_IDX.
REQ-018 SHALL ignore distance-1 matches (h1), because the core forwards WB to EX.
REQ-019 SHALL accept the candidate when en=1, the candidate is valid, and there is no hazard: it raises iq_ready[candidate], and at the next edge registers instr_out=instr, issue_valid=1 and issue_src=candidate, then sets rr_ptr=candidate+1 mod NUM_IQ.
REQ-020 SHALL handle an illegal candidate without a hazard by accepting it, but registering instr_out=NOP_INSN and issue_valid=0, pulsing illegal_drop, and advancing rr_ptr.
REQ-021 SHALL, on a hazard with en=1, hold iq_ready=0, register a bubble (NOP_INSN, issue_valid=0), increment stall_cnt (saturating at 16'hFFFF), and keep rr_ptr unchanged so the same queue is retried.
REQ-022 SHALL, with en=0 or no valid queue, register a bubble, keep iq_ready=0, and leave rr_ptr and stall_cnt unchanged.
REQ-023 SHALL shift the history every cycle (h3<=h2, h2<=h1, h1<=new slot), bubbles included.
REQ-024 SHALL require iq_valid and iq_instr to be held stable by the queue until iq_ready; a valid that drops before being accepted is not an error.
REQ-025 SHALL give an issue latency of one cycle from acceptance to instr_out.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force instr_out=NOP_INSN, issue_valid=0, issue_src=0, illegal_drop=0, stall_cnt=0, rr_ptr=0, all history we=0, and iq_ready=0.
REQ-027 SHALL, on reset asserted mid-stall, discard the pending instruction without consuming it (it remains in its queue).
REQ-028 SHALL begin issuing at the first edge after rst_n deasserts, with IQ0 having priority.

Verification
REQ-029 SHALL be verified for round-robin: all four queues valid, each with independent instructions -> issue_src sequence 0,1,2,3,0 on consecutive cycles, with no bubbles.
REQ-030 SHALL be verified for distance-1: A (write r3), then immediately B (rs1=r3), from IQ0 -> B issued the next cycle with no bubble and stall_cnt=0.
REQ-031 SHALL be verified for distance-2: A (write r3), X (independent), B (rs1=r3) -> exactly 2 bubbles before B, and stall_cnt=2.
REQ-032 SHALL be verified for immediates and S0: a candidate with use_imm=1 whose rs2 field matches h2.rd, and a writer with rd=S0_IDX -> no stall in either case.
REQ-033 SHALL be verified for illegal instructions: an illegal instruction in IQ2 -> iq_ready[2] pulses, illegal_drop=1 for one cycle, instr_out=NOP_INSN, and issue_valid=0.
REQ-034 SHALL be verified for reset during a stall: rst_n low while B is stalled -> outputs at reset values and B not consumed; after release B issues with no hazard.
